// File: rtl/rgb_pwm_decoder.sv
// Measures the high time of three PWM lines over back-to-back fixed windows and
// reports one saturated duty value per channel through a valid/ready handshake.
module rgb_pwm_decoder #(
    parameter int WINDOW = 256,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RGB_R,
    input  logic              RGB_G,
    input  logic              RGB_B,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    typedef enum logic {FLUSH, ACCUM} state_t;

    localparam logic [DUTY_W-1:0] WIN_LAST = DUTY_W'(WINDOW - 1);

    state_t            state_reg, state_next;
    logic              flush_cnt_reg, flush_cnt_next;
    logic              accum_en;
    logic [DUTY_W-1:0] win_cnt_reg;
    logic              win_end;
    logic              load_reg;
    logic              out_valid_reg;
    logic              overrun_reg;
    logic [2:0]        sync1_reg, sync2_reg;
    logic [2:0]        pwm_in;
    logic [DUTY_W:0]   acc_reg  [3];
    logic [DUTY_W:0]   snap_reg [3];
    logic [DUTY_W-1:0] duty_reg [3];

    assign pwm_in = {RGB_B, RGB_G, RGB_R};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pwm_in;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= FLUSH;
            flush_cnt_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // FLUSH spends two cycles so the synchroniser holds only post-reset samples.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            FLUSH: begin
                flush_cnt_next = 1'b1;
                if (flush_cnt_reg)
                    state_next = ACCUM;
            end
            ACCUM:   state_next = ACCUM;
            default: state_next = FLUSH;
        endcase
    end

    always_comb begin
        accum_en = (state_reg == ACCUM);
    end

    always_ff @(posedge clk) begin
        if (reset)
            win_cnt_reg <= '0;
        else if (accum_en)
            win_cnt_reg <= win_cnt_reg + 1'b1;
    end

    assign win_end = accum_en && (win_cnt_reg == WIN_LAST);

    // The final sample is folded into a snapshot so the next window starts clean;
    // the duty registers load from that snapshot one edge later.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [DUTY_W:0] bit_ext;
            assign bit_ext = {{DUTY_W{1'b0}}, sync2_reg[gi]};

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_reg[gi]  <= '0;
                    snap_reg[gi] <= '0;
                    duty_reg[gi] <= '0;
                end else begin
                    if (win_end) begin
                        snap_reg[gi] <= acc_reg[gi] + bit_ext;
                        acc_reg[gi]  <= '0;
                    end else if (accum_en) begin
                        acc_reg[gi]  <= acc_reg[gi] + bit_ext;
                    end
                    if (load_reg)
                        duty_reg[gi] <= snap_reg[gi][DUTY_W] ? {DUTY_W{1'b1}}
                                                             : snap_reg[gi][DUTY_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            load_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            load_reg <= win_end;
            if (load_reg) begin
                out_valid_reg <= 1'b1;
                if (out_valid_reg && !out_ready)
                    overrun_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign duty_r    = duty_reg[0];
    assign duty_g    = duty_reg[1];
    assign duty_b    = duty_reg[2];
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Scoreboarded bench for rgb_pwm_decoder: the driver counts high cycles per window
// and queues timestamped results; the monitor models the handshake and compares.
module tb_rgb_pwm_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       RGB_R, RGB_G, RGB_B;
    logic [7:0] duty_r, duty_g, duty_b;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         arr;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    rgb_pwm_decoder #(.WINDOW(256), .DUTY_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .RGB_R     (RGB_R),
        .RGB_G     (RGB_G),
        .RGB_B     (RGB_B),
        .duty_r    (duty_r),
        .duty_g    (duty_g),
        .duty_b    (duty_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    // Expected-behaviour state, updated on each rising edge from the queued results.
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic [7:0] m_r = 8'd0, m_g = 8'd0, m_b = 8'd0;
    int         edge_cnt = 0;
    bit         armed = 1'b0;
    bit         first_done = 1'b0;

    initial begin
        bit accept;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid  = 1'b0;
                m_ovr    = 1'b0;
                m_r = 8'd0; m_g = 8'd0; m_b = 8'd0;
                edge_cnt = 0;
                armed    = 1'b1;
            end else begin
                edge_cnt++;
                accept = m_valid && out_ready;
                if (accept)
                    $display("xfer edge=%0d r=%0d g=%0d b=%0d", edge_cnt, m_r, m_g, m_b);
                while (q.size() > 0 && q[0].arr < edge_cnt) begin
                    check("stale_result", 32'(edge_cnt), 32'(q[0].arr));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].arr == edge_cnt) begin
                    if (m_valid && !accept)
                        m_ovr = 1'b1;
                    m_r = q[0].r; m_g = q[0].g; m_b = q[0].b;
                    m_valid = 1'b1;
                    void'(q.pop_front());
                end else if (accept) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset)
                first_done = 1'b0;
            if (armed) begin
                if (!reset && out_valid && !first_done) begin
                    check("first_valid_latency", 32'(edge_cnt), 32'd259);
                    first_done = 1'b1;
                end
                check("out_valid", 32'(out_valid), 32'(m_valid));
                check("overrun", 32'(overrun), 32'(m_ovr));
                if (m_valid || reset) begin
                    check("duty_r", 32'(duty_r), 32'(m_r));
                    check("duty_g", 32'(duty_g), 32'(m_g));
                    check("duty_b", 32'(duty_b), 32'(m_b));
                end
            end
        end
    end

    // Each segment starts with a 5-cycle reset, then drives ncyc cycles; cycle c is
    // sampled on the (c+1)-th edge after release, and a window's result is due 3 edges
    // after its last sample.
    task automatic run_seg(input int seg, input int ncyc);
        int   cr, cg, cb, pos, w;
        logic r, g, b, rdy;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        repeat (5) @(posedge clk);
        cr = 0; cg = 0; cb = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0)
                reset = 1'b0;
            pos = c % 256;
            w   = c / 256;
            r = 1'b0; g = 1'b0; b = 1'b0; rdy = 1'b1;
            case (seg)
                1: begin r = 1'b1; end
                2: begin r = (pos < 128); g = (pos < 200); b = (pos < 64); end
                3: begin
                    r   = (w == 0) ? (pos < 32) : (w == 1) ? (pos < 96) : 1'b0;
                    rdy = (c == 519);
                end
                4: begin
                    r = 1'($urandom); g = 1'($urandom); b = ($urandom_range(0, 3) == 0);
                    rdy = (pos == 2) && (c >= 258);
                end
                5: begin
                    r = 1'($urandom); g = ($urandom_range(0, 7) != 0); b = 1'($urandom);
                    rdy = ($urandom_range(0, 3) == 0);
                end
                6: begin r = 1'b1; g = 1'($urandom); rdy = 1'($urandom); end
                default: begin r = 1'b1; g = 1'($urandom); b = (pos >= 250); end
            endcase
            RGB_R = r; RGB_G = g; RGB_B = b; out_ready = rdy;
            @(posedge clk);
            cr += int'(r); cg += int'(g); cb += int'(b);
            if (pos == 255) begin
                q.push_back('{r: sat8(cr), g: sat8(cg), b: sat8(cb), arr: c + 4});
                cr = 0; cg = 0; cb = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        RGB_R = 1'b0; RGB_G = 1'b0; RGB_B = 1'b0;
        out_ready = 1'b0;
        run_seg(1, 600);
        run_seg(2, 600);
        run_seg(3, 560);
        run_seg(4, 1100);
        run_seg(5, 1500);
        run_seg(6, 358);
        run_seg(7, 800);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
